// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam logic [7:0] CONFLICT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: the arbiter is the master, the memory the slave.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              mem_start;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_rwn;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_ready;

    modport master (
        output mem_start, mem_address, mem_rwn, mem_data_in,
        input  mem_data_out, mem_ready
    );

    modport slave (
        input  mem_start, mem_address, mem_rwn, mem_data_in,
        output mem_data_out, mem_ready
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way arbiter: round-robin on ties, or port 1 always wins when fixed is set.
module mem_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       win
);

    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = fixed ? 1'b1 : ~last;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              rwn0,
    input  logic              rwn1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt,
    output logic [7:0]        conflict_cnt,
    mem_arbiter_if.master     mem
);

    state_t            state;
    state_t            state_nxt;
    logic              win;
    logic              grant;
    logic              last;
    logic              gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rwn_q;
    logic [DATA_W-1:0] wdata_q;

    mem_arb_rr u_rr (
        .req   ({req1, req0}),
        .last  (last),
        .fixed (FIXED_PRIO),
        .win   (win)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        unique case (state)
            S_IDLE:  if ((req0 || req1) && mem.mem_ready) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mem.mem_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != S_IDLE);
        mem.mem_start = (state == S_ISSUE);
        done0         = (state == S_DONE) && !gnt_q;
        done1         = (state == S_DONE) &&  gnt_q;
    end

    assign grant           = (state == S_IDLE) && (state_nxt == S_ISSUE);
    assign gnt             = gnt_q;
    assign mem.mem_address = addr_q;
    assign mem.mem_rwn     = rwn_q;
    assign mem.mem_data_in = wdata_q;

    // NOTE: the latched request fields are reset too, so the memory bus is defined before the first grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last         <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            rwn_q        <= 1'b1;
            wdata_q      <= '0;
            rdata        <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant) begin
                last    <= win;
                gnt_q   <= win;
                addr_q  <= win ? addr1  : addr0;
                rwn_q   <= win ? rwn1   : rwn0;
                wdata_q <= win ? wdata1 : wdata0;
            end
            // Writes complete without touching rdata, so the last read value stays visible.
            if (state == S_WAIT && mem.mem_ready && rwn_q) begin
                rdata <= mem.mem_data_out;
            end
            if (state == S_IDLE && req0 && req1 && mem.mem_ready && conflict_cnt != CONFLICT_MAX) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter side by side against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rwn;
        logic [DW-1:0] wdata;
        int            gap;
    } txn_t;

    logic clk = 1'b0;
    logic [1:0] reset_v;
    logic [1:0] req0_v, req1_v, rwn0_v, rwn1_v;
    logic [1:0][AW-1:0] addr0_v, addr1_v;
    logic [1:0][DW-1:0] wdata0_v, wdata1_v;
    wire  [1:0] done0_v, done1_v, busy_v, gnt_v, start_v, mrwn_v;
    wire  [1:0][DW-1:0] rdata_v, mdin_v;
    wire  [1:0][AW-1:0] maddr_v;
    wire  [1:0][7:0] conf_v;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    mem_arbiter_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem_arr [256];
        logic          ready;
        logic [1:0]    cnt;
        logic [DW-1:0] dout;

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g == 1)) dut (
            .clk          (clk),
            .reset        (reset_v[g]),
            .req0         (req0_v[g]),
            .req1         (req1_v[g]),
            .addr0        (addr0_v[g]),
            .addr1        (addr1_v[g]),
            .rwn0         (rwn0_v[g]),
            .rwn1         (rwn1_v[g]),
            .wdata0       (wdata0_v[g]),
            .wdata1       (wdata1_v[g]),
            .done0        (done0_v[g]),
            .done1        (done1_v[g]),
            .rdata        (rdata_v[g]),
            .busy         (busy_v[g]),
            .gnt          (gnt_v[g]),
            .conflict_cnt (conf_v[g]),
            .mem          (bus[g])
        );

        assign bus[g].mem_ready    = ready;
        assign bus[g].mem_data_out = dout;
        assign start_v[g] = bus[g].mem_start;
        assign maddr_v[g] = bus[g].mem_address;
        assign mrwn_v[g]  = bus[g].mem_rwn;
        assign mdin_v[g]  = bus[g].mem_data_in;

        // Memory model: busy for addr[1:0]+1 cycles after start; contents reload on reset.
        always_ff @(posedge clk or posedge reset_v[g]) begin
            if (reset_v[g]) begin
                ready <= 1'b1;
                cnt   <= '0;
                dout  <= '0;
                for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            end else if (bus[g].mem_start) begin
                ready <= 1'b0;
                cnt   <= bus[g].mem_address[1:0];
                if (bus[g].mem_rwn) dout <= mem_arr[bus[g].mem_address];
                else mem_arr[bus[g].mem_address] <= bus[g].mem_data_in;
            end else if (!ready) begin
                if (cnt == 2'd0) ready <= 1'b1;
                else cnt <= cnt - 2'd1;
            end
        end
    end

    // Requester state, indexed d*2+port.
    txn_t q [4][$];
    txn_t cur [4];
    bit   active [4], granted [4], dropped [4], drop_en [4];
    int   gap_cnt [4], start_cyc [4];

    // Reference model, indexed by DUT.
    logic [DW-1:0] mem_ref [2][256];
    bit            have_txn [2], owner [2], last_m [2];
    int            gnt_cyc [2], done_cyc [2], next_free [2], exp_conf [2];
    logic [AW-1:0] t_addr [2];
    logic          t_rwn [2];
    logic [DW-1:0] t_wdata [2], t_rval [2], exp_rdata [2];

    int            obs_done_cyc [2][2];
    logic [DW-1:0] obs_rdata [2][2];
    logic [7:0]    ord [2];

    int cyc, checks, errors;
    bit rand_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string tg(input string n, input int d);
        return $sformatf("%s_d%0d", n, d);
    endfunction

    task automatic push(input int i, input logic [AW-1:0] a, input logic rwn,
                        input logic [DW-1:0] wd, input int gap);
        txn_t t;
        t.addr = a; t.rwn = rwn; t.wdata = wd; t.gap = gap;
        q[i].push_back(t);
    endtask

    task automatic model_reset(input int d);
        have_txn[d]  = 1'b0;
        last_m[d]    = 1'b1;
        exp_conf[d]  = 0;
        exp_rdata[d] = '0;
        next_free[d] = cyc + 1;
        for (int i = 0; i < 256; i++) mem_ref[d][i] = init_word(i);
        for (int p = 0; p < 2; p++) begin
            active[d*2+p]  = 1'b0;
            granted[d*2+p] = 1'b0;
            dropped[d*2+p] = 1'b0;
            gap_cnt[d*2+p] = rand_phase ? int'($urandom_range(0, 3)) : 0;
        end
        req0_v[d] = 1'b0;
        req1_v[d] = 1'b0;
    endtask

    task automatic check_dut(input int d);
        bit in_txn, is_done;
        if (have_txn[d] && cyc == done_cyc[d] && t_rwn[d]) exp_rdata[d] = t_rval[d];
        in_txn  = have_txn[d] && cyc > gnt_cyc[d] && cyc <= done_cyc[d];
        is_done = have_txn[d] && cyc == done_cyc[d];
        check(tg("busy", d),      busy_v[d],  in_txn);
        check(tg("mem_start", d), start_v[d], have_txn[d] && cyc == gnt_cyc[d] + 1);
        check(tg("done0", d),     done0_v[d], is_done && !owner[d]);
        check(tg("done1", d),     done1_v[d], is_done && owner[d]);
        check(tg("rdata", d),     rdata_v[d], exp_rdata[d]);
        check(tg("conflict", d),  conf_v[d],  exp_conf[d]);
        if (in_txn) begin
            check(tg("gnt", d),      gnt_v[d],   owner[d]);
            check(tg("mem_addr", d), maddr_v[d], t_addr[d]);
            check(tg("mem_rwn", d),  mrwn_v[d],  t_rwn[d]);
            if (!t_rwn[d]) check(tg("mem_din", d), mdin_v[d], t_wdata[d]);
        end
        if (done0_v[d]) begin
            obs_done_cyc[d][0] = cyc; obs_rdata[d][0] = rdata_v[d]; ord[d] = {ord[d][6:0], 1'b0};
        end
        if (done1_v[d]) begin
            obs_done_cyc[d][1] = cyc; obs_rdata[d][1] = rdata_v[d]; ord[d] = {ord[d][6:0], 1'b1};
        end
    endtask

    task automatic drive_dut(input int d);
        bit r0, r1, w;
        int i;
        if (have_txn[d] && cyc == done_cyc[d]) begin
            i = d*2 + int'(owner[d]);
            active[i]   = 1'b0;
            gap_cnt[i]  = cur[i].gap;
            have_txn[d] = 1'b0;
        end
        // Occasionally abort a transaction that is waiting on the memory.
        if (rand_phase && have_txn[d] && cyc >= gnt_cyc[d] + 2 && $urandom_range(0, 39) == 0) begin
            reset_v[d] = 1'b1;
            model_reset(d);
            return;
        end
        for (int p = 0; p < 2; p++) begin
            i = d*2 + p;
            if (active[i]) begin
                if (granted[i] && drop_en[i] && !dropped[i] && $urandom_range(0, 1) == 0) dropped[i] = 1'b1;
            end else if (gap_cnt[i] > 0) begin
                gap_cnt[i]--;
            end else if (q[i].size() > 0) begin
                cur[i]       = q[i].pop_front();
                active[i]    = 1'b1;
                granted[i]   = 1'b0;
                dropped[i]   = 1'b0;
                drop_en[i]   = rand_phase && $urandom_range(0, 3) == 0;
                start_cyc[i] = cyc;
            end
        end
        req0_v[d]   = active[d*2] && !dropped[d*2];
        req1_v[d]   = active[d*2+1] && !dropped[d*2+1];
        addr0_v[d]  = active[d*2]   ? cur[d*2].addr    : AW'($urandom);
        addr1_v[d]  = active[d*2+1] ? cur[d*2+1].addr  : AW'($urandom);
        rwn0_v[d]   = active[d*2]   ? cur[d*2].rwn     : 1'($urandom);
        rwn1_v[d]   = active[d*2+1] ? cur[d*2+1].rwn   : 1'($urandom);
        wdata0_v[d] = active[d*2]   ? cur[d*2].wdata   : DW'($urandom);
        wdata1_v[d] = active[d*2+1] ? cur[d*2+1].wdata : DW'($urandom);

        r0 = req0_v[d];
        r1 = req1_v[d];
        if (cyc >= next_free[d] && (r0 || r1)) begin
            if (r0 && r1 && exp_conf[d] < 255) exp_conf[d]++;
            w = (r0 && r1) ? ((d == 1) ? 1'b1 : !last_m[d]) : r1;
            i = d*2 + int'(w);
            last_m[d]    = w;
            owner[d]     = w;
            have_txn[d]  = 1'b1;
            gnt_cyc[d]   = cyc;
            done_cyc[d]  = cyc + 4 + int'(cur[i].addr[1:0]);
            next_free[d] = done_cyc[d] + 1;
            granted[i]   = 1'b1;
            t_addr[d]    = cur[i].addr;
            t_rwn[d]     = cur[i].rwn;
            t_wdata[d]   = cur[i].wdata;
            if (cur[i].rwn) t_rval[d] = mem_ref[d][cur[i].addr];
            else mem_ref[d][cur[i].addr] = cur[i].wdata;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        reset_v = 2'b00;
        for (int d = 0; d < 2; d++) check_dut(d);
        for (int d = 0; d < 2; d++) drive_dut(d);
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < 4; i++) if (q[i].size() != 0 || active[i]) return 1'b0;
        return !have_txn[0] && !have_txn[1];
    endfunction

    task automatic run(input int max_cycles);
        int n = 0;
        while (!all_idle() && n < max_cycles) begin
            step();
            n++;
        end
        check("drain", all_idle(), 1'b1);
    endtask

    task automatic reset_all();
        reset_v = 2'b11;
        for (int d = 0; d < 2; d++) model_reset(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; rand_phase = 1'b0;
        reset_v = 2'b11;
        req0_v = '0; req1_v = '0; rwn0_v = '1; rwn1_v = '1;
        addr0_v = '0; addr1_v = '0; wdata0_v = '0; wdata1_v = '0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            ord[d] = '0;
            for (int p = 0; p < 2; p++) begin
                obs_done_cyc[d][p] = -1;
                obs_rdata[d][p] = '0;
            end
        end
        repeat (3) @(posedge clk);
        step();

        // Single read of 0x02: done0 six cycles after the request appears.
        for (int d = 0; d < 2; d++) push(d*2, 8'h02, 1'b1, '0, 0);
        run(50);
        for (int d = 0; d < 2; d++) begin
            check(tg("lat_a2", d), obs_done_cyc[d][0] - start_cyc[d*2], 6);
            check(tg("rd_02", d), obs_rdata[d][0], init_word(2));
        end

        // Write through port 1, read back through port 0.
        for (int d = 0; d < 2; d++) push(d*2+1, 8'hF4, 1'b0, 16'hBEEF, 0);
        run(50);
        for (int d = 0; d < 2; d++) push(d*2, 8'hF4, 1'b1, '0, 0);
        run(50);
        for (int d = 0; d < 2; d++) check(tg("rd_beef", d), obs_rdata[d][0], 16'hBEEF);

        // Both ports held busy for four transactions each from a fresh reset.
        reset_all();
        for (int d = 0; d < 2; d++) begin
            ord[d] = '0;
            for (int k = 0; k < 4; k++) begin
                push(d*2,   AW'($urandom), 1'b1, '0, 0);
                push(d*2+1, AW'($urandom), 1'b1, '0, 0);
            end
        end
        run(200);
        check("order_rr", ord[0], 8'h55);
        check("order_fixed", ord[1], 8'hF0);

        // Long tie stream to drive the conflict counter into saturation.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 270; k++) begin
                push(d*2,   AW'($urandom_range(0, 31)), 1'($urandom), DW'($urandom), 0);
                push(d*2+1, AW'($urandom_range(0, 31)), 1'($urandom), DW'($urandom), 0);
            end
        end
        run(8000);
        for (int d = 0; d < 2; d++) check(tg("conf_sat", d), conf_v[d], 8'd255);

        // Random traffic with gaps, mid-transaction request drops and aborting resets.
        rand_phase = 1'b1;
        repeat (3000) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() == 0 && !active[i] && $urandom_range(0, 2) == 0)
                    push(i, AW'($urandom_range(0, 31)), 1'($urandom), DW'($urandom),
                         int'($urandom_range(0, 4)));
            end
            step();
        end
        rand_phase = 1'b0;
        run(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
